// File: rtl/mem_port_req_adapter.sv
// Val/rdy front-end for one port of the fixed-latency 4-port memory: issues en/we pulses,
// tracks ops for LAT cycles and queues responses. Define MEM_PORT_REQ_ADAPTER_FWD_EN to forward RAW data.
module mem_port_req_adapter #(
  parameter int WIDTH      = 32,
  parameter int IDX_SIZE   = 4,
  parameter int LAT        = 5,
  parameter int RESP_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_val,
  output logic                req_rdy,
  input  logic [IDX_SIZE-1:0] req_addr,
  input  logic                req_we,
  input  logic [WIDTH-1:0]    req_wdata,
  output logic                resp_val,
  input  logic                resp_rdy,
  output logic                resp_we,
  output logic [WIDTH-1:0]    resp_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [IDX_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  input  logic [WIDTH-1:0]    mem_read_data
);
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(LAT + RESP_DEPTH + 1);

  typedef struct packed {
    logic                we;
    logic [IDX_SIZE-1:0] addr;
`ifdef MEM_PORT_REQ_ADAPTER_FWD_EN
    logic [WIDTH-1:0]    wdata;
    logic                fwd;
    logic [WIDTH-1:0]    fdata;
`endif
  } stage_t;

  logic [LAT:1]   vld_pipe;
  stage_t         stg [1:LAT];
  stage_t         stg_in;
  logic           run, fire, credit_ok, push, pop;
  logic [CW-1:0]  in_flight;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [PW:0]    count;
  logic [WIDTH-1:0] push_data;
  logic           fifo_we   [RESP_DEPTH];
  logic [WIDTH-1:0] fifo_data [RESP_DEPTH];

  // Holds req_rdy low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset)
    if (!reset) run <= 1'b0;
    else        run <= 1'b1;

  assign fire      = req_val && req_rdy;
  assign mem_en    = fire;
  assign mem_we    = fire && req_we;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  always_comb begin
    in_flight = '0;
    for (int k = 1; k <= LAT; k++) in_flight = in_flight + CW'(vld_pipe[k]);
  end

  // Every tracked op owns a FIFO slot, so a completion can never overflow.
  assign credit_ok = (in_flight + CW'(count)) < CW'(RESP_DEPTH);

`ifdef MEM_PORT_REQ_ADAPTER_FWD_EN
  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_data;
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = LAT-1; k >= 1; k--)
      if (vld_pipe[k] && stg[k].we && stg[k].addr == req_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = stg[k].wdata;
      end
  end
  assign req_rdy = run && credit_ok;
`else
  logic hazard;
  // Stage LAT is excluded: that write has already committed in the memory.
  always_comb begin
    hazard = 1'b0;
    for (int k = 1; k < LAT; k++)
      if (vld_pipe[k] && stg[k].we && stg[k].addr == req_addr) hazard = 1'b1;
    hazard = hazard && !req_we;
  end
  assign req_rdy = run && credit_ok && !hazard;
`endif

  always_comb begin
    stg_in      = '0;
    stg_in.we   = req_we;
    stg_in.addr = req_addr;
`ifdef MEM_PORT_REQ_ADAPTER_FWD_EN
    stg_in.wdata = req_wdata;
    stg_in.fwd   = fwd_hit && !req_we;
    stg_in.fdata = fwd_data;
`endif
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[LAT-1:1], fire};

  always_ff @(posedge clk) begin
    stg[1] <= stg_in;
    for (int k = 2; k <= LAT; k++) stg[k] <= stg[k-1];
  end

  // Write acks carry zero rather than the memory's undefined write-cycle output.
  always_comb begin
    push_data = stg[LAT].we ? '0 : mem_read_data;
`ifdef MEM_PORT_REQ_ADAPTER_FWD_EN
    if (stg[LAT].fwd) push_data = stg[LAT].fdata;
`endif
  end

  assign push       = vld_pipe[LAT];
  assign resp_val   = (count != '0);
  assign pop        = resp_val && resp_rdy;
  assign resp_we    = fifo_we[rd_ptr];
  assign resp_rdata = fifo_data[rd_ptr];

  always_ff @(posedge clk)
    if (push) begin
      fifo_we[wr_ptr]   <= stg[LAT].we;
      fifo_data[wr_ptr] <= push_data;
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
endmodule
